fact_job_scheduler: RTL and testbench
=====================================

Name: fact_job_scheduler

Overview:
- Bus-master controller that shares one memory-mapped factorial peripheral between NREQ requesters.
- Arbitrates pending requests round-robin, then runs one job at a time over the peripheral's byte bus. Each job writes n, pulses start, polls the done flag, reads back the 32-bit fn byte by byte, and clears the flag.
- Returns the result to the granted requester as a one-cycle response.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 1024, maximum poll cycles before a job is aborted with an error
IDW, 3, width of resp_id (must be at least clog2(NREQ))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request; held high until acknowledged
req_n  in  8*NREQ  operand n, slice i belongs to requester i
req_ack  out  NREQ  one-hot, one-cycle acknowledge; req_n[i] captured on this cycle
resp_valid  out  1  one-cycle result strobe
resp_id  out  IDW  index of the requester the result belongs to
resp_fn  out  32  factorial result (0 on error)
resp_err  out  1  timeout flag, valid with resp_valid
busy  out  1  high from grant until the resp_valid cycle, inclusive
writeBus  out  1  peripheral write strobe
addressBus  out  32  peripheral address
dataBusOut  out  8  write data to peripheral
dataBusIn  in  8  combinational read data from peripheral

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including addressBus=0, writeBus=0 and resp_*=0.
  - RR pointer is set to NREQ-1, so requester 0 has first priority.
- Peripheral map:
  - 0x0: n register (write).
  - 0x4..0x7: fn bytes 0..3, little-endian (read).
  - 0x8: CNF register. bit0 = int_en, bit1 = start, bit2 = done (sticky, set only while int_en=1).
- States and transitions (one cycle each unless noted):
  - IDLE: if any req_valid, grant the first set bit searching from ptr+1 with wrap-around. Pulse req_ack[g], latch n and id, set ptr=g, go to WR_N. Otherwise stay in IDLE.
  - WR_N: writeBus=1, addr=0x0, data=n.
  - WR_GO: writeBus=1, addr=0x8, data=0x03 (int_en and start set).
  - WR_REL: writeBus=1, addr=0x8, data=0x01 (start released; a one-cycle start pulse).
  - POLL: writeBus=0, addr=0x8. Sample dataBusIn[2] each cycle.
    - If it is 1, go to RD0.
    - Otherwise increment the poll counter. When the counter reaches TIMEOUT, set err=1 and go to CLR.
  - RD0..RD3: addr=0x4..0x7. Capture dataBusIn into fn bytes 0..3 in the same cycle.
  - CLR: writeBus=1, addr=0x8, data=0x00 (clears done and int_en).
  - RESP: resp_valid=1 with resp_id, resp_fn, resp_err. fn is forced to 0 when err=1. Go to IDLE.
- Outside write states: writeBus=0 and dataBusOut=0. addressBus holds its last value in IDLE.
- Latency from req_ack to resp_valid (req_ack cycle = cycle 0):
  - Success: 10+k cycles, where k = number of POLL cycles that saw done=0.
  - Timeout: resp_valid at cycle 6+TIMEOUT.
- Other boundary rules:
  - There is no response backpressure.
  - req_valid changes during a job are ignored; a request is acknowledged only in IDLE.
  - A requester that drops req_valid before its ack loses the request, with no error.
  - A simultaneous new request and RESP is served in the next IDLE cycle, so at least one IDLE cycle separates jobs.
  - Reset mid-job aborts the job: no response is issued, and bus outputs are 0 immediately.
  - n=0 is passed through unchanged; the result comes from the peripheral.

Test Plan:
- Single request: req_valid[0], n=5, peripheral done after 3 cycles -> writes 0x0←5, 0x8←0x03, 0x8←0x01; reads 0x4..0x7; 0x8←0x00. Response resp_id=0, resp_fn=120, resp_err=0 at cycle 13 after ack.
- Round-robin: both requesters held high, n=3 and n=4 -> acks in order 0,1,0,1. Responses 6, 24, 6, 24, each with the matching id.
- Byte assembly: n=12 -> resp_fn=0x1C8CFC00 (479001600). All four bytes are checked.
- Timeout: TIMEOUT=8, peripheral never sets done -> CLR write, then resp_err=1 and resp_fn=0 at cycle 14 after ack.
- Reset during POLL: rst=0 -> writeBus=0, addressBus=0 and busy=0 asynchronously. No resp_valid. After release, requester 0 is granted first.
- Late arrival: req_valid[1] rises during a requester-0 job -> acknowledged in the first IDLE cycle after RESP.

Source files
------------

// File: rtl/fact_job_scheduler.sv
// -----------------------------------------------------------------------------
// fact_job_scheduler
//
// Shares one memory-mapped factorial peripheral between NREQ requesters.
// Pending requests are granted round-robin; each granted job is run over the
// peripheral's byte bus as a fixed sequence:
//   write n -> pulse start -> poll done -> read fn[31:0] bytewise -> clear CNF
// and the result is returned to the granted requester as a one-cycle strobe.
//
// Peripheral map: 0x0 n (W), 0x4..0x7 fn bytes 0..3 little-endian (R),
//                 0x8 CNF {done(sticky), start, int_en}.
//
// Handshake: req_valid[i] is held by the requester until req_ack[i] pulses for
// one cycle in IDLE; req_n[i] is captured on that cycle. resp_valid is a
// single-cycle strobe with no backpressure; resp_id/resp_fn/resp_err are only
// meaningful (and otherwise 0) while it is high.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   req_valid/req_n   per-requester request and 8-bit operand (slice i)
//   req_ack           one-hot acknowledge, combinational in the grant cycle
//   resp_valid/id/fn/err  result strobe, requester index, result, timeout
//   busy              high from the grant cycle through the response cycle
//   writeBus/addressBus/dataBusOut/dataBusIn  peripheral byte bus
// -----------------------------------------------------------------------------
module fact_job_scheduler #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024,
    parameter int IDW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_n,
    output logic [NREQ-1:0]   req_ack,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_fn,
    output logic              resp_err,
    output logic              busy,
    output logic              writeBus,
    output logic [31:0]       addressBus,
    output logic [7:0]        dataBusOut,
    input  logic [7:0]        dataBusIn
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_N,
        S_WR_GO,
        S_WR_REL,
        S_POLL,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CLR,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     n_q, n_d;
    logic [31:0]    fn_q, fn_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q;

    // Round-robin search: first pending requester after the last grant.
    logic grant_any;
    int   grant_idx;

    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = 0;
        idx       = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr_q) + off) % NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        n_d        = n_q;
        fn_d       = fn_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ack    = '0;
        writeBus   = 1'b0;
        dataBusOut = 8'h00;
        addressBus = addr_q;   // IDLE and RESP keep the last address on the bus
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_fn    = 32'h0;
        resp_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rst gates the combinational ack so every output is 0 in reset.
                if (grant_any && rst) begin
                    req_ack[grant_idx] = 1'b1;
                    ptr_d   = IDW'(grant_idx);
                    id_d    = IDW'(grant_idx);
                    n_d     = req_n[8*grant_idx +: 8];
                    fn_d    = 32'h0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WR_N;
                end
            end
            S_WR_N: begin
                writeBus   = 1'b1;
                addressBus = 32'h0;
                dataBusOut = n_q;
                state_d    = S_WR_GO;
            end
            S_WR_GO: begin
                writeBus   = 1'b1;
                addressBus = 32'h8;
                dataBusOut = 8'h03;
                state_d    = S_WR_REL;
            end
            S_WR_REL: begin
                writeBus   = 1'b1;
                addressBus = 32'h8;
                dataBusOut = 8'h01;
                state_d    = S_POLL;
            end
            S_POLL: begin
                addressBus = 32'h8;
                if (dataBusIn[2]) begin
                    state_d = S_RD0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    // TIMEOUT polls have already seen done=0; this is one more.
                    err_d   = 1'b1;
                    state_d = S_CLR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD0: begin
                addressBus = 32'h4;
                fn_d[7:0]  = dataBusIn;
                state_d    = S_RD1;
            end
            S_RD1: begin
                addressBus = 32'h5;
                fn_d[15:8] = dataBusIn;
                state_d    = S_RD2;
            end
            S_RD2: begin
                addressBus  = 32'h6;
                fn_d[23:16] = dataBusIn;
                state_d     = S_RD3;
            end
            S_RD3: begin
                addressBus  = 32'h7;
                fn_d[31:24] = dataBusIn;
                state_d     = S_CLR;
            end
            S_CLR: begin
                writeBus   = 1'b1;
                addressBus = 32'h8;
                dataBusOut = 8'h00;
                state_d    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_fn    = err_q ? 32'h0 : fn_q;
                resp_err   = err_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE) || (req_ack != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            n_q     <= 8'h00;
            fn_q    <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            fn_q    <= fn_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addressBus;
        end
    end

endmodule

// File: tb/tb_fact_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fact_job_scheduler
//
// Bench for fact_job_scheduler with TIMEOUT=8. A behavioural factorial
// peripheral answers the byte bus with a programmable done delay. Requesters
// hold req_valid while they have unacknowledged jobs. A negedge monitor logs
// acks, responses and bus writes; each test task predicts grant order,
// results and latency from the block's rules and compares against the logs.
// -----------------------------------------------------------------------------
module tb_fact_job_scheduler;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_n = '0;
    logic [NREQ-1:0]   req_ack;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [31:0]       resp_fn;
    logic              resp_err;
    logic              busy;
    logic              writeBus;
    logic [31:0]       addressBus;
    logic [7:0]        dataBusOut;
    logic [7:0]        dataBusIn;

    fact_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ack    (req_ack),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_fn    (resp_fn),
        .resp_err   (resp_err),
        .busy       (busy),
        .writeBus   (writeBus),
        .addressBus (addressBus),
        .dataBusOut (dataBusOut),
        .dataBusIn  (dataBusIn)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    // ---------------- behavioural peripheral ----------------
    int          per_delay = 0;   // polls that will see done=0 after start
    logic [7:0]  p_n;
    logic        p_int_en, p_done, p_run;
    int          p_cnt;
    logic [31:0] p_fn;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_n <= 8'h0; p_int_en <= 1'b0; p_done <= 1'b0;
            p_run <= 1'b0; p_cnt <= 0; p_fn <= 32'h0;
        end else begin
            if (writeBus && addressBus == 32'h0) p_n <= dataBusOut;
            if (writeBus && addressBus == 32'h8) begin
                p_int_en <= dataBusOut[0];
                if (!dataBusOut[0]) p_done <= 1'b0;
                if (dataBusOut[1]) begin
                    p_run <= 1'b1;
                    p_cnt <= per_delay;
                    p_fn  <= fact(int'(p_n));
                end
            end
            if (p_run && !(writeBus && addressBus == 32'h8 && dataBusOut[1])) begin
                if (p_cnt == 0) begin
                    p_run <= 1'b0;
                    if (p_int_en) p_done <= 1'b1;
                end else begin
                    p_cnt <= p_cnt - 1;
                end
            end
        end
    end

    always_comb begin
        dataBusIn = 8'h00;
        case (addressBus)
            32'h4: dataBusIn = p_fn[7:0];
            32'h5: dataBusIn = p_fn[15:8];
            32'h6: dataBusIn = p_fn[23:16];
            32'h7: dataBusIn = p_fn[31:24];
            32'h8: dataBusIn = {5'b0, p_done, 1'b0, p_int_en};
            default: dataBusIn = 8'h00;
        endcase
    end

    // ---------------- requester driver ----------------
    int         issued[NREQ] = '{default: 0};
    int         acked[NREQ]  = '{default: 0};
    logic [7:0] n_of[NREQ]   = '{default: 8'h0};

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]     = (issued[i] != acked[i]);
            req_n[8*i +: 8]  = n_of[i];
        end
    end

    task automatic issue(input int r, input logic [7:0] n);
        n_of[r]   = n;
        issued[r] = issued[r] + 1;
    endtask

    // ---------------- monitor logs ----------------
    int          ack_id_q[$], ack_cyc_q[$];
    logic [7:0]  ack_n_q[$];
    int          rsp_id_q[$], rsp_cyc_q[$];
    logic [31:0] rsp_fn_q[$];
    logic        rsp_err_q[$];
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          busy_bad = 0;
    int          ack_bad  = 0;
    logic        inflight = 1'b0;
    logic        exp_busy;

    always @(negedge clk) begin
        if (!rst) begin
            inflight = 1'b0;
        end else begin
            exp_busy = inflight || (req_ack != '0);
            if (busy !== exp_busy) busy_bad++;
            if (req_ack != '0) begin
                if ($countones(req_ack) != 1) ack_bad++;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ack[i]) begin
                        ack_id_q.push_back(i);
                        ack_cyc_q.push_back(cyc);
                        ack_n_q.push_back(req_n[8*i +: 8]);
                        acked[i] = acked[i] + 1;
                    end
                end
                inflight = 1'b1;
            end
            if (writeBus) begin
                wr_addr_q.push_back(addressBus);
                wr_data_q.push_back(dataBusOut);
            end
            if (resp_valid) begin
                rsp_id_q.push_back(int'(resp_id));
                rsp_fn_q.push_back(resp_fn);
                rsp_err_q.push_back(resp_err);
                rsp_cyc_q.push_back(cyc);
                inflight = 1'b0;
            end
        end
    end

    // ---------------- reference model helpers ----------------
    int exp_last = NREQ - 1;   // last granted requester, as the block should see it

    function automatic int rr_next(input int last, input int pend[NREQ]);
        for (int off = 1; off <= NREQ; off++) begin
            if (pend[(last + off) % NREQ] > 0) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic int exp_latency(input int d);
        return (d > TIMEOUT) ? (6 + TIMEOUT) : (10 + d);
    endfunction

    task automatic wait_resps(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_id_q.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (rsp_id_q.size() < target) begin
            errors++;
            $display("FAIL wait_resp: got %0d responses, required %0d", rsp_id_q.size(), target);
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n;
        n = 0;
        while (ack_id_q.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (ack_id_q.size() < target) begin
            errors++;
            $display("FAIL wait_ack: got %0d acks, required %0d", ack_id_q.size(), target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (writeBus !== 1'b0)    begin errors++; $display("FAIL rst_writeBus: got %b, required 0", writeBus); end
        checks++; if (addressBus !== 32'h0) begin errors++; $display("FAIL rst_address: got %h, required 0", addressBus); end
        checks++; if (dataBusOut !== 8'h0)  begin errors++; $display("FAIL rst_dataOut: got %h, required 0", dataBusOut); end
        checks++; if (resp_valid !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid: got %b, required 0", resp_valid); end
        checks++; if (resp_fn !== 32'h0 || resp_id !== '0 || resp_err !== 1'b0)
            begin errors++; $display("FAIL rst_resp_fields: got id=%0d fn=%h err=%b, required 0", resp_id, resp_fn, resp_err); end
        checks++; if (busy !== 1'b0 || req_ack !== '0)
            begin errors++; $display("FAIL rst_busy_ack: got busy=%b ack=%b, required 0", busy, req_ack); end
        @(negedge clk);
        rst = 1'b1;
        exp_last = NREQ - 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        int base_a, base_r, base_w;
        logic [31:0] ea[4];
        logic [7:0]  ed[4];
        base_a = ack_id_q.size(); base_r = rsp_id_q.size(); base_w = wr_addr_q.size();
        per_delay = 3;
        issue(0, 8'd5);
        wait_resps(base_r + 1, 100);
        exp_last = 0;
        ea = '{32'h0, 32'h8, 32'h8, 32'h8};
        ed = '{8'd5, 8'h03, 8'h01, 8'h00};
        checks++; if (ack_id_q[base_a] !== 0)   begin errors++; $display("FAIL single_ack_id: got %0d, required 0", ack_id_q[base_a]); end
        checks++; if (ack_n_q[base_a] !== 8'd5) begin errors++; $display("FAIL single_ack_n: got %0d, required 5", ack_n_q[base_a]); end
        checks++; if (rsp_id_q[base_r] !== 0)   begin errors++; $display("FAIL single_resp_id: got %0d, required 0", rsp_id_q[base_r]); end
        checks++; if (rsp_fn_q[base_r] !== 32'd120) begin errors++; $display("FAIL single_resp_fn: got %0d, required 120", rsp_fn_q[base_r]); end
        checks++; if (rsp_err_q[base_r] !== 1'b0) begin errors++; $display("FAIL single_resp_err: got %b, required 0", rsp_err_q[base_r]); end
        checks++; if (rsp_cyc_q[base_r] - ack_cyc_q[base_a] !== 13)
            begin errors++; $display("FAIL single_latency: got %0d, required 13", rsp_cyc_q[base_r] - ack_cyc_q[base_a]); end
        checks++; if (wr_addr_q.size() - base_w !== 4)
            begin errors++; $display("FAIL single_write_count: got %0d, required 4", wr_addr_q.size() - base_w); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr_q[base_w+i] !== ea[i] || wr_data_q[base_w+i] !== ed[i]) begin
                errors++;
                $display("FAIL single_write%0d: got %h<-%h, required %h<-%h", i,
                         wr_addr_q[base_w+i], wr_data_q[base_w+i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int base_a, base_r, d, g;
        int pend[NREQ];
        int exp_ids[$];
        base_a = ack_id_q.size(); base_r = rsp_id_q.size();
        d = int'($urandom_range(0, TIMEOUT));
        per_delay = d;
        pend = '{2, 2};
        issue(0, 8'd3); issue(0, 8'd3);
        issue(1, 8'd4); issue(1, 8'd4);
        while (rr_next(exp_last, pend) >= 0) begin
            g = rr_next(exp_last, pend);
            exp_ids.push_back(g);
            pend[g]--;
            exp_last = g;
        end
        wait_resps(base_r + 4, 300);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ack_id_q[base_a+j] !== exp_ids[j] || rsp_id_q[base_r+j] !== exp_ids[j]) begin
                errors++;
                $display("FAIL rr_order%0d: got ack=%0d resp=%0d, required %0d", j,
                         ack_id_q[base_a+j], rsp_id_q[base_r+j], exp_ids[j]);
            end
            checks++;
            if (rsp_fn_q[base_r+j] !== fact(exp_ids[j] == 0 ? 3 : 4)) begin
                errors++;
                $display("FAIL rr_fn%0d: got %0d, required %0d", j, rsp_fn_q[base_r+j], fact(exp_ids[j] == 0 ? 3 : 4));
            end
            checks++;
            if (rsp_cyc_q[base_r+j] - ack_cyc_q[base_a+j] !== exp_latency(d)) begin
                errors++;
                $display("FAIL rr_latency%0d: got %0d, required %0d", j,
                         rsp_cyc_q[base_r+j] - ack_cyc_q[base_a+j], exp_latency(d));
            end
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ack_cyc_q[base_a+j+1] - rsp_cyc_q[base_r+j] !== 1) begin
                errors++;
                $display("FAIL rr_gap%0d: got %0d cycles, required 1", j, ack_cyc_q[base_a+j+1] - rsp_cyc_q[base_r+j]);
            end
        end
    endtask

    task automatic test_byte_assembly();
        int base_r;
        logic [31:0] exp_fn, got;
        base_r = rsp_id_q.size();
        exp_fn = 32'h1C8C_FC00;
        per_delay = int'($urandom_range(0, TIMEOUT));
        issue(1, 8'd12);
        exp_last = 1;
        wait_resps(base_r + 1, 100);
        got = rsp_fn_q[base_r];
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (got[8*b +: 8] !== exp_fn[8*b +: 8]) begin
                errors++;
                $display("FAIL bytes_fn_byte%0d: got %h, required %h", b, got[8*b +: 8], exp_fn[8*b +: 8]);
            end
        end
    endtask

    // Delays straddling the timeout: 8 still succeeds, 9 and "never" abort.
    task automatic test_timeout();
        int delays[3];
        int base_a, base_r, base_w, d;
        logic to;
        delays = '{TIMEOUT, TIMEOUT + 1, 100000};
        for (int t = 0; t < 3; t++) begin
            base_a = ack_id_q.size(); base_r = rsp_id_q.size(); base_w = wr_addr_q.size();
            d = delays[t];
            to = (d > TIMEOUT);
            per_delay = d;
            issue(0, 8'd7);
            exp_last = 0;
            wait_resps(base_r + 1, 200);
            checks++;
            if (rsp_err_q[base_r] !== to || rsp_fn_q[base_r] !== (to ? 32'h0 : fact(7))) begin
                errors++;
                $display("FAIL timeout_result d=%0d: got err=%b fn=%0d, required err=%b fn=%0d", d,
                         rsp_err_q[base_r], rsp_fn_q[base_r], to, to ? 32'h0 : fact(7));
            end
            checks++;
            if (rsp_cyc_q[base_r] - ack_cyc_q[base_a] !== exp_latency(d)) begin
                errors++;
                $display("FAIL timeout_latency d=%0d: got %0d, required %0d", d,
                         rsp_cyc_q[base_r] - ack_cyc_q[base_a], exp_latency(d));
            end
            checks++;
            if (wr_addr_q.size() - base_w !== 4 || wr_addr_q[base_w+3] !== 32'h8 || wr_data_q[base_w+3] !== 8'h00) begin
                errors++;
                $display("FAIL timeout_clr d=%0d: got %0d writes, last %h<-%h, required 4 writes ending 8<-00", d,
                         wr_addr_q.size() - base_w, wr_addr_q[base_w+3], wr_data_q[base_w+3]);
            end
        end
    endtask

    task automatic test_late_arrival();
        int base_a, base_r;
        base_a = ack_id_q.size(); base_r = rsp_id_q.size();
        per_delay = 4;
        issue(0, 8'd6);
        wait_acks(base_a + 1, 20);
        repeat (3) @(posedge clk);
        issue(1, 8'd7);
        wait_resps(base_r + 2, 200);
        exp_last = 1;
        checks++;
        if (ack_id_q[base_a+1] !== 1 || ack_cyc_q[base_a+1] - rsp_cyc_q[base_r] !== 1) begin
            errors++;
            $display("FAIL late_ack: got id=%0d at +%0d after resp, required id=1 at +1",
                     ack_id_q[base_a+1], ack_cyc_q[base_a+1] - rsp_cyc_q[base_r]);
        end
        checks++;
        if (rsp_fn_q[base_r] !== 32'd720 || rsp_fn_q[base_r+1] !== 32'd5040) begin
            errors++;
            $display("FAIL late_fn: got %0d,%0d, required 720,5040", rsp_fn_q[base_r], rsp_fn_q[base_r+1]);
        end
    endtask

    task automatic test_random();
        int base_a, base_r, d, g, mask;
        int pend[NREQ];
        int exp_ids[$];
        logic [31:0] efn;
        for (int it = 0; it < 8; it++) begin
            base_a = ack_id_q.size(); base_r = rsp_id_q.size();
            exp_ids.delete();
            d = int'($urandom_range(0, TIMEOUT + 3));
            per_delay = d;
            mask = int'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                pend[i] = mask[i] ? 1 : 0;
                if (mask[i]) issue(i, 8'($urandom_range(0, 12)));
            end
            while (rr_next(exp_last, pend) >= 0) begin
                g = rr_next(exp_last, pend);
                exp_ids.push_back(g);
                pend[g]--;
                exp_last = g;
            end
            wait_resps(base_r + exp_ids.size(), 300);
            for (int j = 0; j < exp_ids.size(); j++) begin
                efn = (d > TIMEOUT) ? 32'h0 : fact(int'(n_of[exp_ids[j]]));
                checks++;
                if (rsp_id_q[base_r+j] !== exp_ids[j] || rsp_fn_q[base_r+j] !== efn ||
                    rsp_err_q[base_r+j] !== (d > TIMEOUT)) begin
                    errors++;
                    $display("FAIL rand%0d_resp%0d: got id=%0d fn=%0d err=%b, required id=%0d fn=%0d err=%b",
                             it, j, rsp_id_q[base_r+j], rsp_fn_q[base_r+j], rsp_err_q[base_r+j],
                             exp_ids[j], efn, d > TIMEOUT);
                end
                checks++;
                if (rsp_cyc_q[base_r+j] - ack_cyc_q[base_a+j] !== exp_latency(d)) begin
                    errors++;
                    $display("FAIL rand%0d_latency%0d: got %0d, required %0d", it, j,
                             rsp_cyc_q[base_r+j] - ack_cyc_q[base_a+j], exp_latency(d));
                end
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_job();
        int base_a, base_r, rsp_at_release;
        base_a = ack_id_q.size(); base_r = rsp_id_q.size();
        per_delay = 100000;
        issue(1, 8'd9);
        wait_acks(base_a + 1, 20);
        repeat (6) @(posedge clk);   // now inside the polling phase
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (writeBus !== 1'b0 || addressBus !== 32'h0 || dataBusOut !== 8'h0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got wr=%b addr=%h dout=%h busy=%b rv=%b, required all 0",
                     writeBus, addressBus, dataBusOut, busy, resp_valid);
        end
        issue(0, 8'd3);
        issue(1, 8'd4);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (req_valid !== 2'b11 || req_ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold: got valid=%b ack=%b busy=%b, required valid=11 ack=0 busy=0",
                     req_valid, req_ack, busy);
        end
        per_delay = 2;
        rsp_at_release = rsp_id_q.size();
        @(negedge clk);
        rst = 1'b1;
        exp_last = NREQ - 1;
        checks++;
        if (rsp_at_release !== base_r) begin
            errors++;
            $display("FAIL midrst_no_resp: got %0d responses, required %0d", rsp_at_release, base_r);
        end
        wait_resps(base_r + 2, 200);
        exp_last = 1;
        checks++;
        if (ack_id_q[base_a+1] !== 0 || ack_id_q[base_a+2] !== 1 || rsp_id_q[base_r] !== 0 || rsp_fn_q[base_r] !== 32'd6) begin
            errors++;
            $display("FAIL midrst_order: got acks %0d,%0d first resp id=%0d fn=%0d, required acks 0,1 resp id=0 fn=6",
                     ack_id_q[base_a+1], ack_id_q[base_a+2], rsp_id_q[base_r], rsp_fn_q[base_r]);
        end
    endtask

    task automatic test_monitors();
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL busy_window: got %0d bad cycles, required 0", busy_bad); end
        checks++;
        if (ack_bad !== 0) begin errors++; $display("FAIL ack_onehot: got %0d bad acks, required 0", ack_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_byte_assembly();
        test_timeout();
        test_late_arrival();
        test_random();
        test_reset_mid_job();
        test_monitors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
